// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared fetch bundle type, default depth and branch predecode
package fetch_queue_pkg;

    localparam int FQ_DEPTH_DEFAULT = 8;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] raw_instr;
        logic        is_slot;
    } fetch_data_t;

    // Branch/jump predecode: REGIMM, J/JAL/BEQ/BNE/BLEZ/BGTZ, and JR/JALR
    function automatic logic is_branch(input logic [31:0] raw_instr);
        logic [5:0] opcode;
        logic [5:0] funct;
        opcode = raw_instr[31:26];
        funct  = raw_instr[5:0];
        is_branch = (opcode == 6'b000001) ||
                    ((opcode >= 6'b000010) && (opcode <= 6'b000111)) ||
                    ((opcode == 6'b000000) && ((funct == 6'b001000) || (funct == 6'b001001)));
    endfunction

endpackage

// File: rtl/fetch_queue_ctl.sv
// rtl/fetch_queue_ctl.sv - head/tail/occupancy bookkeeping and dequeue-width selection
module fetch_queue_ctl
    import fetch_queue_pkg::*;
#(
    parameter  int FQ_DEPTH = FQ_DEPTH_DEFAULT,
    localparam int FQ_WIDTH = $clog2(FQ_DEPTH)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [1:0]          in_valid,
    input  logic                flush,
    input  logic                out_ready,
    input  logic                br_h0,
    input  logic                br_h1,
    output logic [FQ_WIDTH-1:0] head,
    output logic [FQ_WIDTH-1:0] tail,
    output logic [FQ_WIDTH:0]   cnt,
    output logic                in_ready,
    output logic                enq_fire,
    output logic [1:0]          navail
);

    localparam int CW = FQ_WIDTH + 1;
    localparam logic [FQ_WIDTH:0] READY_MAX = CW'(FQ_DEPTH - 2);

    logic [1:0] nenq;
    logic [1:0] ndeq;

    // Room for a full pair is judged from registered occupancy only
    always_comb begin
        in_ready = (cnt <= READY_MAX);
        enq_fire = in_valid[1] && in_ready && !flush;
        nenq     = 2'd0;
        if (enq_fire) begin
            nenq = in_valid[0] ? 2'd2 : 2'd1;
        end
    end

    // A branch is only released together with its delay slot
    always_comb begin
        navail = 2'd2;
        if (cnt == '0) begin
            navail = 2'd0;
        end else if (br_h0) begin
            navail = (cnt == CW'(1)) ? 2'd0 : 2'd2;
        end else if ((cnt == CW'(1)) || br_h1) begin
            navail = 2'd1;
        end
        ndeq = out_ready ? navail : 2'd0;
    end

    // Pointer and occupancy update; flush empties the queue on the next edge
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            head <= head + FQ_WIDTH'(ndeq);
            tail <= tail + FQ_WIDTH'(nenq);
            cnt  <= cnt + CW'(nenq) - CW'(ndeq);
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - two-wide fetch-to-decode instruction buffer with delay-slot pairing
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter  int FQ_DEPTH = FQ_DEPTH_DEFAULT,
    localparam int FQ_WIDTH = $clog2(FQ_DEPTH)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [1:0]            in_valid,
    input  logic [31:0]           in_pc,
    input  logic [1:0][31:0]      in_instr,
    output logic                  in_ready,
    output fetch_data_t [1:0]     out_data,
    input  logic                  out_ready,
    input  logic                  flush,
    output logic [FQ_WIDTH:0]     count
);

    logic [31:0]         pc_mem    [FQ_DEPTH];
    logic [31:0]         instr_mem [FQ_DEPTH];

    logic [FQ_WIDTH-1:0] head;
    logic [FQ_WIDTH-1:0] tail;
    logic [FQ_WIDTH-1:0] head_p1;
    logic [FQ_WIDTH-1:0] tail_p1;
    logic [FQ_WIDTH:0]   cnt;
    logic                enq_fire;
    logic [1:0]          navail;
    logic                br_h0;
    logic                br_h1;

    assign head_p1 = head + FQ_WIDTH'(1);
    assign tail_p1 = tail + FQ_WIDTH'(1);
    assign br_h0   = is_branch(instr_mem[head]);
    assign br_h1   = is_branch(instr_mem[head_p1]);
    assign count   = cnt;

    fetch_queue_ctl #(
        .FQ_DEPTH (FQ_DEPTH)
    ) u_ctl (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .flush     (flush),
        .out_ready (out_ready),
        .br_h0     (br_h0),
        .br_h1     (br_h1),
        .head      (head),
        .tail      (tail),
        .cnt       (cnt),
        .in_ready  (in_ready),
        .enq_fire  (enq_fire),
        .navail    (navail)
    );

    // Entry storage; contents are meaningless outside the head..tail window so no reset
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            pc_mem[tail]    <= in_pc;
            instr_mem[tail] <= in_instr[1];
            if (in_valid[0]) begin
                pc_mem[tail_p1]    <= in_pc + 32'd4;
                instr_mem[tail_p1] <= in_instr[0];
            end
        end
    end

    // Present the oldest one or two entries; unused lanes read as all-zero
    always_comb begin
        out_data = '0;
        if (navail != 2'd0) begin
            out_data[1].valid     = 1'b1;
            out_data[1].pc        = pc_mem[head];
            out_data[1].raw_instr = instr_mem[head];
        end
        if (navail == 2'd2) begin
            out_data[0].valid     = 1'b1;
            out_data[0].pc        = pc_mem[head_p1];
            out_data[0].raw_instr = instr_mem[head_p1];
            out_data[0].is_slot   = br_h0;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam logic [31:0] ADDU = 32'h0043_0821;
    localparam logic [31:0] ORI  = 32'h3421_0001;
    localparam logic [31:0] BEQ  = 32'h1000_0004;
    localparam logic [31:0] NOP  = 32'h0000_0000;
    localparam logic [31:0] JR   = 32'h03E0_0008;

    logic              clk = 1'b0;
    logic              resetn;
    logic [1:0]        in_valid;
    logic [31:0]       in_pc;
    logic [1:0][31:0]  in_instr;
    logic              in_ready;
    fetch_data_t [1:0] out_data;
    logic              out_ready;
    logic              flush;
    logic [3:0]        count;

    int n_cmp = 0;
    int n_err = 0;

    fetch_queue #(.FQ_DEPTH(8)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ready (out_ready),
        .flush     (flush),
        .count     (count)
    );

    always #5 clk = ~clk;

    function automatic fetch_data_t mk(input logic [31:0] pc, input logic [31:0] ins, input logic slot);
        fetch_data_t d;
        d.valid = 1'b1;
        d.pc = pc;
        d.raw_instr = ins;
        d.is_slot = slot;
        return d;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        in_valid = 2'b00; in_pc = '0; in_instr = '0; out_ready = 1'b0; flush = 1'b0;
        #12;
        n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out: got %h want 0", out_data); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    task automatic test_pair;
        out_ready = 1'b1;
        in_valid = 2'b11; in_pc = 32'hBFC0_0000; in_instr[1] = ADDU; in_instr[0] = ORI;
        tick();
        in_valid = 2'b00;
        n_cmp++; if (out_data[1] !== mk(32'hBFC0_0000, ADDU, 1'b0)) begin n_err++; $display("FAIL pair_out1: got %h want %h", out_data[1], mk(32'hBFC0_0000, ADDU, 1'b0)); end
        n_cmp++; if (out_data[0] !== mk(32'hBFC0_0004, ORI, 1'b0)) begin n_err++; $display("FAIL pair_out0: got %h want %h", out_data[0], mk(32'hBFC0_0004, ORI, 1'b0)); end
        n_cmp++; if (count !== 4'd2) begin n_err++; $display("FAIL pair_count: got %0d want 2", count); end
        tick();
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL pair_drained: got %0d want 0", count); end
    endtask

    task automatic test_branch_slot;
        out_ready = 1'b1;
        in_valid = 2'b10; in_pc = 32'h100; in_instr[1] = BEQ; in_instr[0] = ADDU;
        tick();
        in_valid = 2'b00;
        n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL br_wait_out: got %h want 0", out_data); end
        n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL br_wait_count: got %0d want 1", count); end
        in_valid = 2'b10; in_pc = 32'h104; in_instr[1] = NOP;
        tick();
        in_valid = 2'b00;
        n_cmp++; if (out_data[1] !== mk(32'h100, BEQ, 1'b0)) begin n_err++; $display("FAIL br_out1: got %h want %h", out_data[1], mk(32'h100, BEQ, 1'b0)); end
        n_cmp++; if (out_data[0] !== mk(32'h104, NOP, 1'b1)) begin n_err++; $display("FAIL br_out0_slot: got %h want %h", out_data[0], mk(32'h104, NOP, 1'b1)); end
        tick();
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL br_drained: got %0d want 0", count); end
    endtask

    task automatic test_deferred;
        out_ready = 1'b0;
        in_valid = 2'b11; in_pc = 32'h200; in_instr[1] = ADDU; in_instr[0] = JR;
        tick();
        in_valid = 2'b10; in_pc = 32'h208; in_instr[1] = NOP;
        tick();
        in_valid = 2'b00;
        n_cmp++; if (out_data[1] !== mk(32'h200, ADDU, 1'b0)) begin n_err++; $display("FAIL defer_out1: got %h want %h", out_data[1], mk(32'h200, ADDU, 1'b0)); end
        n_cmp++; if (out_data[0] !== '0) begin n_err++; $display("FAIL defer_out0: got %h want 0", out_data[0]); end
        out_ready = 1'b1;
        tick();
        n_cmp++; if (out_data[1] !== mk(32'h204, JR, 1'b0)) begin n_err++; $display("FAIL defer_jr: got %h want %h", out_data[1], mk(32'h204, JR, 1'b0)); end
        n_cmp++; if (out_data[0] !== mk(32'h208, NOP, 1'b1)) begin n_err++; $display("FAIL defer_slot: got %h want %h", out_data[0], mk(32'h208, NOP, 1'b1)); end
        tick();
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL defer_drained: got %0d want 0", count); end
    endtask

    task automatic test_fill;
        out_ready = 1'b0;
        in_instr[1] = ADDU; in_instr[0] = ORI;
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready_%0d: got %b want 1", k, in_ready); end
            in_valid = 2'b11; in_pc = 32'h1000 + 32'(8 * k);
            tick();
        end
        in_valid = 2'b10; in_pc = 32'h1018;
        tick();
        in_valid = 2'b00;
        n_cmp++; if (count !== 4'd7) begin n_err++; $display("FAIL fill_count7: got %0d want 7", count); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fill_not_ready: got %b want 0", in_ready); end
        in_valid = 2'b11; in_pc = 32'hDEAD_0000;
        tick();
        in_valid = 2'b00;
        n_cmp++; if (count !== 4'd7) begin n_err++; $display("FAIL fill_ignored: got %0d want 7", count); end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (out_data[1] !== mk(32'h1000 + 32'(8 * k), ADDU, 1'b0)) begin n_err++; $display("FAIL drain_out1_%0d: got %h want %h", k, out_data[1], mk(32'h1000 + 32'(8 * k), ADDU, 1'b0)); end
            n_cmp++; if (out_data[0] !== ((k < 3) ? mk(32'h1004 + 32'(8 * k), ORI, 1'b0) : fetch_data_t'('0))) begin n_err++; $display("FAIL drain_out0_%0d: got %h", k, out_data[0]); end
            tick();
        end
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL fill_drained: got %0d want 0", count); end
    endtask

    task automatic test_wrap;
        out_ready = 1'b1;
        in_instr[1] = ADDU; in_instr[0] = ORI;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) begin
                n_cmp++; if (out_data[1] !== mk(32'h4000 + 32'(8 * (i - 1)), ADDU, 1'b0)) begin n_err++; $display("FAIL wrap_out1_%0d: got %h", i, out_data[1]); end
                n_cmp++; if (out_data[0] !== mk(32'h4004 + 32'(8 * (i - 1)), ORI, 1'b0)) begin n_err++; $display("FAIL wrap_out0_%0d: got %h", i, out_data[0]); end
            end
            in_valid = 2'b11; in_pc = 32'h4000 + 32'(8 * i);
            tick();
        end
        in_valid = 2'b00;
        n_cmp++; if (out_data[1] !== mk(32'h4098, ADDU, 1'b0)) begin n_err++; $display("FAIL wrap_last: got %h want %h", out_data[1], mk(32'h4098, ADDU, 1'b0)); end
        tick();
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL wrap_drained: got %0d want 0", count); end
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        in_instr[1] = ADDU; in_instr[0] = ORI;
        in_valid = 2'b11; in_pc = 32'h500; tick();
        in_valid = 2'b11; in_pc = 32'h508; tick();
        in_valid = 2'b10; in_pc = 32'h510; tick();
        in_valid = 2'b00;
        n_cmp++; if (count !== 4'd5) begin n_err++; $display("FAIL flush_pre_count: got %0d want 5", count); end
        flush = 1'b1; in_valid = 2'b11; in_pc = 32'h600;
        tick();
        flush = 1'b0; in_valid = 2'b00;
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL flush_count: got %0d want 0", count); end
        n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL flush_out: got %h want 0", out_data); end
        tick();
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL flush_dropped: got %0d want 0", count); end
        out_ready = 1'b1;
        in_valid = 2'b11; in_pc = 32'h700;
        tick();
        in_valid = 2'b00;
        n_cmp++; if (out_data[1] !== mk(32'h700, ADDU, 1'b0)) begin n_err++; $display("FAIL flush_refill: got %h want %h", out_data[1], mk(32'h700, ADDU, 1'b0)); end
        tick();
    endtask

    task automatic test_async_reset;
        out_ready = 1'b0;
        in_instr[1] = ADDU; in_instr[0] = ORI;
        in_valid = 2'b11; in_pc = 32'h800; tick();
        in_valid = 2'b11; in_pc = 32'h808; tick();
        in_valid = 2'b00;
        n_cmp++; if (count !== 4'd4) begin n_err++; $display("FAIL arst_pre_count: got %0d want 4", count); end
        #3;
        resetn = 1'b0;
        #1;
        n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL arst_out: got %h want 0", out_data); end
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL arst_count: got %0d want 0", count); end
        @(posedge clk); #1;
        resetn = 1'b1;
        tick();
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL arst_release: got %0d want 0", count); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL arst_in_ready: got %b want 1", in_ready); end
    endtask

    initial begin
        test_reset();
        test_pair();
        test_branch_slot();
        test_deferred();
        test_fill();
        test_wrap();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
